// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encodings and the default operand width.
package serial_adder_pkg;

    localparam int SA_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sa_state_e;

    // The counter must reach WIDTH (one past the last bit index) without wrapping.
    function automatic int sa_cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/full_adder_struct.sv
// Combinational one-bit full-adder cell, reused by the bit-serial adder.
module full_adder_struct (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    logic half_sum;
    logic gen;
    logic prop;

    assign half_sum = A ^ B;
    assign gen      = A & B;
    assign prop     = Cin & half_sum;
    assign S        = half_sum ^ Cin;
    assign Cout     = gen | prop;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder with a start/done handshake, one full-adder step per clock.
// Optional signed-overflow output is built when SERIAL_ADDER_OVF_EN is defined.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int              CNT_W    = sa_cnt_width(WIDTH);
    localparam int              SUM_SH_W = WIDTH - 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    sa_state_e          state_q,  state_d;
    logic [WIDTH-1:0]   a_sh_q,   a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,   b_sh_d;
    logic [SUM_SH_W-1:0] sum_sh_q, sum_sh_d;
    logic               carry_q,  carry_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic [WIDTH-1:0]   sum_q,    sum_d;
    logic               cout_q,   cout_d;

    logic fa_s;
    logic fa_cout;
    logic last_bit;

    full_adder_struct u_fa (
        .A    (a_sh_q[0]),
        .B    (b_sh_q[0]),
        .Cin  (carry_q),
        .S    (fa_s),
        .Cout (fa_cout)
    );

    assign last_bit = (cnt_q == LAST_CNT);

    // The final sum bit never enters sum_sh; it goes straight into the result with the other WIDTH-1 bits.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        sum_d    = sum_q;
        cout_d   = cout_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    a_sh_d   = a;
                    b_sh_d   = b;
                    sum_sh_d = '0;
                    carry_d  = cin;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = SUM_SH_W'({fa_s, sum_sh_q} >> 1);
                carry_d  = fa_cout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    sum_d   = {fa_s, sum_sh_q};
                    cout_d  = fa_cout;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef SERIAL_ADDER_OVF_EN
    localparam logic [CNT_W-1:0] MSB_CNT = CNT_W'(WIDTH - 2);

    logic msb_cin_q, msb_cin_d;
    logic ovf_q,     ovf_d;

    // Carry out of bit WIDTH-2 is the carry into the MSB; overflow is its XOR with the final carry.
    always_comb begin
        msb_cin_d = msb_cin_q;
        ovf_d     = ovf_q;
        if (state_q == ST_RUN) begin
            if (cnt_q == MSB_CNT) begin
                msb_cin_d = fa_cout;
            end
            if (last_bit) begin
                ovf_d = msb_cin_q ^ fa_cout;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msb_cin_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            msb_cin_q <= msb_cin_d;
            ovf_q     <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases, randomized operands against an
// arithmetic reference model, and an exhaustive sweep of a WIDTH=2 instance.
module tb_serial_adder;

    localparam int W  = 8;
    localparam int NW = 2;

`ifdef SERIAL_ADDER_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  a     = '0;
    logic [W-1:0]  b     = '0;
    logic          cin   = 1'b0;
    logic          busy;
    logic          done;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;

    logic          n_start = 1'b0;
    logic [NW-1:0] n_a     = '0;
    logic [NW-1:0] n_b     = '0;
    logic          n_cin   = 1'b0;
    logic          n_busy;
    logic          n_done;
    logic [NW-1:0] n_sum;
    logic          n_cout;
    logic          n_ovf;

    int assert_count = 0;
    int fail_count   = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    serial_adder #(.WIDTH(NW)) dut_narrow (
        .clk   (clk),
        .rst_n (rst_n),
        .start (n_start),
        .a     (n_a),
        .b     (n_b),
        .cin   (n_cin),
        .busy  (n_busy),
        .done  (n_done),
        .sum   (n_sum),
        .cout  (n_cout),
        .ovf   (n_ovf)
    );

    always #5 clk = ~clk;

    // Global safety net in case a bounded wait is somehow bypassed.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time exceeded, observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and two's-complement views of the operands.
    function automatic void refAdd(input int width, input int unsigned av, input int unsigned bv,
                                   input int unsigned cv, output int unsigned rsum,
                                   output logic rcout, output logic rovf);
        int unsigned total;
        int full;
        int half;
        int sav;
        int sbv;
        int ssum;
        full  = 1 << width;
        half  = 1 << (width - 1);
        total = av + bv + cv;
        rsum  = total % full;
        rcout = (total >= full);
        sav   = (int'(av) >= half) ? int'(av) - full : int'(av);
        sbv   = (int'(bv) >= half) ? int'(bv) - full : int'(bv);
        ssum  = sav + sbv + int'(cv);
        rovf  = OVF_EN && ((ssum >= half) || (ssum < -half));
    endfunction

    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        @(negedge clk);
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges from idx0 until done; scrambles operands meanwhile, which must have no effect.
    task automatic waitDone(input int idx0, output int lat, output int busy_cycles);
        lat         = idx0;
        busy_cycles = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cycles++;
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        if (!done) checkOutput("done_timeout", 64'(0), 64'(1));
    endtask

    task automatic checkResult(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        int unsigned rsum;
        logic        rcout;
        logic        rovf;
        refAdd(W, 32'(av), 32'(bv), 32'(cv), rsum, rcout, rovf);
        checkOutput({tag, "_sum"},  64'(sum),  64'(rsum));
        checkOutput({tag, "_cout"}, 64'(cout), 64'(rcout));
        checkOutput({tag, "_ovf"},  64'(ovf),  64'(rovf));
    endtask

    task automatic applyStimulus(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        int lat;
        int bc;
        logic [W-1:0] held;
        launch(av, bv, cv);
        waitDone(0, lat, bc);
        checkOutput({tag, "_latency"}, 64'(lat), 64'(W));
        checkOutput({tag, "_busy_cycles"}, 64'(bc), 64'(W));
        checkOutput({tag, "_busy_at_done"}, 64'(busy), 64'(0));
        checkResult(tag, av, bv, cv);
        held = sum;
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, 64'(done), 64'(0));
        checkOutput({tag, "_sum_held"}, 64'(sum), 64'(held));
    endtask

    task automatic runNarrow(input logic [NW-1:0] av, input logic [NW-1:0] bv, input logic cv);
        int          lat;
        int unsigned rsum;
        logic        rcout;
        logic        rovf;
        @(negedge clk);
        n_a     = av;
        n_b     = bv;
        n_cin   = cv;
        n_start = 1'b1;
        @(negedge clk);
        n_start = 1'b0;
        lat     = 0;
        while (!n_done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        refAdd(NW, 32'(av), 32'(bv), 32'(cv), rsum, rcout, rovf);
        checkOutput("narrow_latency", 64'(lat), 64'(NW));
        checkOutput("narrow_result", 64'({n_cout, n_sum}), 64'({rcout, rsum[NW-1:0]}));
        checkOutput("narrow_ovf", 64'(n_ovf), 64'(rovf));
    endtask

    initial begin
        int lat;
        int bc;
        bit done_seen;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic rc;

        // Everything must read zero while reset is held.
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_done", 64'(done), 64'(0));
        checkOutput("reset_sum",  64'(sum),  64'(0));
        checkOutput("reset_cout", 64'(cout), 64'(0));
        checkOutput("reset_ovf",  64'(ovf),  64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases including carry-out and signed-overflow boundaries.
        applyStimulus("basic_35_4a", 8'h35, 8'h4A, 1'b0);
        applyStimulus("wrap_ff_01",  8'hFF, 8'h01, 1'b0);
        applyStimulus("cin_ff_00",   8'hFF, 8'h00, 1'b1);
        applyStimulus("ovf_7f_01",   8'h7F, 8'h01, 1'b0);
        applyStimulus("ovf_80_80",   8'h80, 8'h80, 1'b0);

        // Start pulses during RUN cycles 3 and 5 must be ignored.
        launch(8'h5A, 8'h21, 1'b1);
        @(negedge clk);
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        checkOutput("ignore_busy", 64'(busy), 64'(1));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 8'h01; b = 8'h02; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(5, lat, bc);
        checkOutput("ignore_latency", 64'(lat), 64'(W));
        checkResult("ignore", 8'h5A, 8'h21, 1'b1);

        // Back-to-back: start held in the DONE cycle launches the next operation.
        launch(8'hC3, 8'h3C, 1'b1);
        waitDone(0, lat, bc);
        checkResult("b2b_first", 8'hC3, 8'h3C, 1'b1);
        a = 8'h9E; b = 8'hA7; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b_busy_next", 64'(busy), 64'(1));
        waitDone(0, lat, bc);
        checkOutput("b2b_latency", 64'(lat), 64'(W));
        checkResult("b2b_second", 8'h9E, 8'hA7, 1'b0);

        // Asynchronous reset in RUN cycle 4 clears outputs at once and suppresses done.
        launch(8'h12, 8'h34, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_busy", 64'(busy), 64'(0));
        checkOutput("midreset_done", 64'(done), 64'(0));
        checkOutput("midreset_sum",  64'(sum),  64'(0));
        checkOutput("midreset_cout", 64'(cout), 64'(0));
        checkOutput("midreset_ovf",  64'(ovf),  64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        checkOutput("midreset_no_done", 64'(done_seen), 64'(0));
        applyStimulus("after_reset", 8'h12, 8'h34, 1'b0);

        // Randomized operands against the arithmetic model.
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            applyStimulus("random", ra, rb, rc);
        end

        // Exhaustive sweep of the two-bit instance.
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                for (int k = 0; k < 2; k++) begin
                    runNarrow(NW'(i), NW'(j), 1'(k));
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
